// File: rtl/divres_bcd_conv.sv
// Sequential binary-to-BCD converter for the divider's quotient and remainder.
// Two double-dabble engines run in lockstep; results and error flag are registered.
module divres_bcd_conv #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      quotient_in,
    input  logic [WIDTH-1:0]      remainder_in,
    input  logic                  overflow_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd,
    output logic                  err
);

    localparam int BCDW = 4 * DIGITS;
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam int STPW = BCDW + WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WIDTH-1:0]  r_q_bin;
    logic [WIDTH-1:0]  r_r_bin;
    logic [BCDW-1:0]   r_q_acc;
    logic [BCDW-1:0]   r_r_acc;
    logic              r_ovf;
    logic [CNTW-1:0]   r_count;
    logic [BCDW-1:0]   r_q_bcd;
    logic [BCDW-1:0]   r_r_bcd;
    logic              r_err;
    logic              r_busy;
    logic              r_done;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_last_step;
    logic [STPW-1:0]   w_q_step;
    logic [STPW-1:0]   w_r_step;

    // One shift-add-3 step: nibbles >= 5 get +3 independently, then {bcd,bin} shifts left.
    function automatic logic [STPW-1:0] dabble_step(input logic [BCDW-1:0]  bcd,
                                                    input logic [WIDTH-1:0] bin);
        logic [BCDW-1:0] adj;
        adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end else begin
                adj[4*d +: 4] = bcd[4*d +: 4];
            end
        end
        return {adj[BCDW-2:0], bin, 1'b0};
    endfunction

    assign w_q_step    = dabble_step(r_q_acc, r_q_bin);
    assign w_r_step    = dabble_step(r_r_acc, r_r_bin);
    assign w_last_step = (r_count == CNTW'(WIDTH - 1));

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_CONV;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_CONV: begin
                if (w_last_step) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_CONV;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs derived from the upcoming state so they can be registered.
    always_comb begin
        w_busy_next = 1'b0;
        w_done_next = 1'b0;
        case (w_next_state)
            S_IDLE: begin
                w_busy_next = 1'b0;
                w_done_next = 1'b0;
            end
            S_CONV: begin
                w_busy_next = 1'b1;
                w_done_next = 1'b0;
            end
            S_DONE: begin
                w_busy_next = 1'b1;
                w_done_next = 1'b1;
            end
            default: begin
                w_busy_next = 1'b0;
                w_done_next = 1'b0;
            end
        endcase
    end

    // Registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_done <= w_done_next;
        end
    end

    // Working registers, engine stepping and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_bin <= '0;
            r_r_bin <= '0;
            r_q_acc <= '0;
            r_r_acc <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
            r_q_bcd <= '0;
            r_r_bcd <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q_bin <= quotient_in;
                        r_r_bin <= remainder_in;
                        r_ovf   <= overflow_in;
                        r_q_acc <= '0;
                        r_r_acc <= '0;
                        r_count <= '0;
                    end
                end
                S_CONV: begin
                    {r_q_acc, r_q_bin} <= w_q_step;
                    {r_r_acc, r_r_bin} <= w_r_step;
                    r_count            <= r_count + CNTW'(1);
                    // Overflow still runs the engines so latency never depends on data.
                    if (w_last_step) begin
                        r_q_bcd <= r_ovf ? '0 : w_q_step[STPW-1 -: BCDW];
                        r_r_bcd <= r_ovf ? '0 : w_r_step[STPW-1 -: BCDW];
                        r_err   <= r_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign q_bcd = r_q_bcd;
    assign r_bcd = r_r_bcd;
    assign err   = r_err;

endmodule

// File: tb/tb_divres_bcd_conv.sv
// Self-checking bench for divres_bcd_conv: vector table, divider sweep,
// random stimulus against an arithmetic model, and hand-written corner sequences.
module tb_divres_bcd_conv;

    localparam int WIDTH  = 6;
    localparam int DIGITS = 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] quotient_in;
    logic [5:0] remainder_in;
    logic       overflow_in;
    logic       busy;
    logic       done;
    logic [7:0] q_bcd;
    logic [7:0] r_bcd;
    logic       err;

    int n_checks = 0;
    int n_errs   = 0;
    logic [7:0] prev_q = 8'h00;
    logic [7:0] prev_r = 8'h00;
    logic       prev_e = 1'b0;

    divres_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .quotient_in(quotient_in), .remainder_in(remainder_in), .overflow_in(overflow_in),
        .busy(busy), .done(done), .q_bcd(q_bcd), .r_bcd(r_bcd), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0] q;
        logic [5:0] r;
        logic       ovf;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
        logic       exp_e;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One conversion from IDLE with latency, busy window and hold-last-result checks.
    task automatic run_conv(input logic [5:0] q, input logic [5:0] r, input logic o,
                            input logic [7:0] eq, input logic [7:0] er, input logic ee,
                            input string name);
        int   lat;
        logic busy_ok;
        logic hold_ok;
        @(negedge clk);
        quotient_in  = q;
        remainder_in = r;
        overflow_in  = o;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start        = 1'b0;
        quotient_in  = 6'($urandom);
        remainder_in = 6'($urandom);
        overflow_in  = 1'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!done && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            if (q_bcd !== prev_q || r_bcd !== prev_r || err !== prev_e) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(WIDTH));
        chk({name, "_busy_conv"}, {31'd0, busy_ok}, 32'd1);
        chk({name, "_hold_prev"}, {31'd0, hold_ok}, 32'd1);
        chk({name, "_q_bcd"}, {24'd0, q_bcd}, {24'd0, eq});
        chk({name, "_r_bcd"}, {24'd0, r_bcd}, {24'd0, er});
        chk({name, "_err"}, {31'd0, err}, {31'd0, ee});
        chk({name, "_busy_done"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk({name, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
        prev_q = eq;
        prev_r = er;
        prev_e = ee;
    endtask

    initial begin
        vecs[0] = '{q: 6'd63, r: 6'd0,  ovf: 1'b0, exp_q: 8'h63, exp_r: 8'h00, exp_e: 1'b0};
        vecs[1] = '{q: 6'd9,  r: 6'd5,  ovf: 1'b0, exp_q: 8'h09, exp_r: 8'h05, exp_e: 1'b0};
        vecs[2] = '{q: 6'd63, r: 6'd63, ovf: 1'b1, exp_q: 8'h00, exp_r: 8'h00, exp_e: 1'b1};
        vecs[3] = '{q: 6'd0,  r: 6'd0,  ovf: 1'b0, exp_q: 8'h00, exp_r: 8'h00, exp_e: 1'b0};
        vecs[4] = '{q: 6'd10, r: 6'd9,  ovf: 1'b0, exp_q: 8'h10, exp_r: 8'h09, exp_e: 1'b0};
        vecs[5] = '{q: 6'd42, r: 6'd7,  ovf: 1'b0, exp_q: 8'h42, exp_r: 8'h07, exp_e: 1'b0};
        vecs[6] = '{q: 6'd1,  r: 6'd62, ovf: 1'b0, exp_q: 8'h01, exp_r: 8'h62, exp_e: 1'b0};

        rst = 1'b1; start = 1'b1;
        quotient_in = 6'd33; remainder_in = 6'd17; overflow_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {13'd0, busy, done, q_bcd, r_bcd, err}, 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_conv(vecs[i].q, vecs[i].r, vecs[i].ovf,
                     vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_e, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            logic [5:0] q;
            logic [5:0] r;
            logic       o;
            q = 6'($urandom); r = 6'($urandom); o = 1'($urandom_range(0, 3) == 0);
            run_conv(q, r, o, o ? 8'h00 : to_bcd(int'(q)), o ? 8'h00 : to_bcd(int'(r)), o,
                     $sformatf("rand%0d", i));
        end

        for (int a = 0; a < 64; a++) begin
            for (int b = 1; b < 64; b++) begin
                run_conv(6'(a / b), 6'(a % b), 1'b0, to_bcd(a / b), to_bcd(a % b), 1'b0,
                         $sformatf("sweep_%0d_%0d", a, b));
            end
        end

        // Start held high: a new conversion every WIDTH+2 cycles, mid-CONV input changes ignored.
        @(negedge clk);
        quotient_in = 6'd10; remainder_in = 6'd9; overflow_in = 1'b0; start = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("hold_done_c%0d", c), {31'd0, done}, {31'd0, ((c % 8) == 6)});
            if ((c % 8) == 6) begin
                chk($sformatf("hold_res_c%0d", c), {15'd0, q_bcd, r_bcd, err}, {15'd0, 8'h10, 8'h09, 1'b0});
            end
            if ((c % 8) == 2) begin
                quotient_in = 6'd55; remainder_in = 6'd33; overflow_in = 1'b1;
            end
            if ((c % 8) == 5) begin
                quotient_in = 6'd10; remainder_in = 6'd9; overflow_in = 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("hold_end_idle", {31'd0, busy}, 32'd0);
        prev_q = 8'h10; prev_r = 8'h09; prev_e = 1'b0;

        // Reset at the third conversion step aborts without a done pulse.
        quotient_in = 6'd31; remainder_in = 6'd2; overflow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", {13'd0, busy, done, q_bcd, r_bcd, err}, 32'd0);
        begin
            logic seen_done;
            seen_done = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (done || busy) seen_done = 1'b1;
            end
            chk("abort_no_done", {31'd0, seen_done}, 32'd0);
        end
        prev_q = 8'h00; prev_r = 8'h00; prev_e = 1'b0;
        run_conv(6'd42, 6'd7, 1'b0, 8'h42, 8'h07, 1'b0, "after_abort");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
